// File: rtl/addsub_scheduler_if.sv
// Requester-side bus of the shared add/subtract scheduler.
// The master modport is the requester side. The slave modport is the scheduler side.
interface addsub_scheduler_if #(
  parameter int SIZE  = 4,
  parameter int WORDS = 2,
  parameter int NREQ  = 2
);
  localparam int W   = SIZE * WORDS;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   ctrl_in;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              done;
  logic [IDW-1:0]    done_id;
  logic [W-1:0]      result;
  logic              carry_out;
  logic              overflow;

  modport master (
    output req, ctrl_in, a_in, b_in,
    input  gnt, busy, done, done_id, result, carry_out, overflow
  );

  modport slave (
    input  req, ctrl_in, a_in, b_in,
    output gnt, busy, done, done_id, result, carry_out, overflow
  );
endinterface

// File: rtl/addsub_scheduler.sv
// Round-robin scheduler sharing one SIZE-bit ripple add/subtract slice.
// Operands are SIZE*WORDS bits wide. One slice is processed per clock, least
// significant slice first, and the carry is held in a register between slices.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches operands on grant
// RUN   | processing slice idx; the last slice raises done and returns to IDLE

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_scheduler #(
  parameter int SIZE  = 4,
  parameter int WORDS = 2,
  parameter int NREQ  = 2
) (
  input logic clk,
  input logic rst,
  addsub_scheduler_if.slave bus
);
  localparam int W   = SIZE * WORDS;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW  = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] rr_ptr, id_reg, sel_id;
  logic [IDW:0]   cand;
  logic           sel_valid;
  logic [IW-1:0]  idx;
  logic           carry_reg, ctrl_reg, ctrl_sel;
  logic [W-1:0]   a_reg, b_reg, a_sel, b_sel;
  logic [SIZE-1:0] sa, sbx, ssum;
  logic [SIZE:0]  c;
  logic           last;

  logic [NREQ-1:0] gnt_reg;
  logic            done_reg, cout_reg, ovf_reg;
  logic [IDW-1:0]  done_id_reg;
  logic [W-1:0]    res_reg;

  // Round-robin pick: the first set request at or after rr_ptr, with wrap-around.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!sel_valid && bus.req[cand[IDW-1:0]]) begin
        sel_valid = 1'b1;
        sel_id    = cand[IDW-1:0];
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    a_sel    = bus.a_in[W-1:0];
    b_sel    = bus.b_in[W-1:0];
    ctrl_sel = bus.ctrl_in[0];
    for (int i = 0; i < NREQ; i++) begin
      if (sel_id == IDW'(i)) begin
        a_sel    = bus.a_in[i*W +: W];
        b_sel    = bus.b_in[i*W +: W];
        ctrl_sel = bus.ctrl_in[i];
      end
    end
  end

  // Select the current slice. For subtract, B is inverted here; the +1 enters
  // only through carry_reg, which is seeded with ctrl at grant.
  always_comb begin
    sa  = '0;
    sbx = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx == IW'(w)) begin
        sa  = a_reg[w*SIZE +: SIZE];
        sbx = b_reg[w*SIZE +: SIZE];
      end
    end
    sbx = sbx ^ {SIZE{ctrl_reg}};
  end

  assign c[0] = carry_reg;
  for (genvar i = 0; i < SIZE; i++) begin : g_slice
    full_adder u_fa (.a(sa[i]), .b(sbx[i]), .cin(c[i]), .s(ssum[i]), .cout(c[i+1]));
  end

  assign last = (idx == IW'(WORDS-1));

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (sel_valid) state_n = RUN;
      RUN:     if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath: grant and latch in IDLE; slice write-back and completion in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      id_reg      <= '0;
      idx         <= '0;
      carry_reg   <= 1'b0;
      ctrl_reg    <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      gnt_reg     <= '0;
      done_reg    <= 1'b0;
      done_id_reg <= '0;
      res_reg     <= '0;
      cout_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      gnt_reg  <= '0;
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            a_reg     <= a_sel;
            b_reg     <= b_sel;
            ctrl_reg  <= ctrl_sel;
            id_reg    <= sel_id;
            idx       <= '0;
            carry_reg <= ctrl_sel;
            gnt_reg   <= {{(NREQ-1){1'b0}}, 1'b1} << sel_id;
          end
        end
        RUN: begin
          for (int w = 0; w < WORDS; w++) begin
            if (idx == IW'(w)) res_reg[w*SIZE +: SIZE] <= ssum;
          end
          carry_reg <= c[SIZE];
          if (last) begin
            done_reg    <= 1'b1;
            done_id_reg <= id_reg;
            cout_reg    <= c[SIZE];
            ovf_reg     <= c[SIZE] ^ c[SIZE-1];
            rr_ptr      <= (id_reg == IDW'(NREQ-1)) ? '0 : id_reg + 1'b1;
            idx         <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.busy      = (state == RUN);
  assign bus.done      = done_reg;
  assign bus.done_id   = done_id_reg;
  assign bus.result    = res_reg;
  assign bus.carry_out = cout_reg;
  assign bus.overflow  = ovf_reg;
endmodule

// File: tb/tb_addsub_scheduler.sv
// Scoreboard bench for addsub_scheduler (SIZE=4, WORDS=2, NREQ=2).
// Expected results are pushed when an operation is issued. A separate monitor
// pops one entry and compares it on every done pulse.
module tb_addsub_scheduler;
  logic clk = 1'b0;
  logic rst;

  addsub_scheduler_if #(.SIZE(4), .WORDS(2), .NREQ(2)) bus ();
  addsub_scheduler #(.SIZE(4), .WORDS(2), .NREQ(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] r;
    logic       c;
    logic       v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: on each done pulse, check the outputs against the oldest expected entry.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done_id=%0d result=%0h want no done", bus.done_id, bus.result);
      end else begin
        mon_e = sb.pop_front();
        chk("done_id",   32'(bus.done_id),   32'(mon_e.id));
        chk("result",    32'(bus.result),    32'(mon_e.r));
        chk("carry_out", 32'(bus.carry_out), 32'(mon_e.c));
        chk("overflow",  32'(bus.overflow),  32'(mon_e.v));
      end
    end
  end

  task automatic do_op(input int id, input logic op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic ec, input logic ev, input bit scramble);
    int n;
    bus.ctrl_in[id]       = op;
    bus.a_in[id*8 +: 8]   = a;
    bus.b_in[id*8 +: 8]   = b;
    sb.push_back('{id, er, ec, ev});
    bus.req[id] = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.gnt == 2'b00 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_onehot", 32'(bus.gnt), 32'(2'b01 << id));
    chk("busy_at_gnt", 32'(bus.busy), 32'd1);
    bus.req[id] = 1'b0;
    if (scramble) begin
      bus.a_in[id*8 +: 8] = 8'hFF;
      bus.b_in[id*8 +: 8] = 8'hEE;
      bus.ctrl_in[id]     = ~op;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done !== 1'b1 && n < 10);
    chk("latency", 32'(n), 32'd2);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
  endtask

  logic [1:0] eg [4];
  logic [7:0] ca [2][2];
  logic [7:0] cb [2][2];
  logic [7:0] cr [2][2];
  logic       cop[2][2];
  logic       cc [2][2];
  int gcount[2];
  int ng, dones, cyc, gid, did;

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.ctrl_in = '0; bus.a_in = '0; bus.b_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt",    32'(bus.gnt),    32'd0);
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(0, 1'b0, 8'h3C, 8'h15, 8'h51, 1'b0, 1'b0, 0);
    do_op(0, 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 0);
    do_op(1, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);
    do_op(0, 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 0);
    do_op(1, 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 0);
    do_op(0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0);
    do_op(0, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 0);
    do_op(1, 1'b1, 8'h20, 8'h10, 8'h10, 1'b1, 1'b0, 0);
    // Operands change in the grant cycle; the result must use the latched values.
    do_op(1, 1'b0, 8'h3C, 8'h15, 8'h51, 1'b0, 1'b0, 1);

    // Reset on the edge after the grant: the operation is dropped and produces no done.
    bus.ctrl_in[0] = 1'b0; bus.a_in[7:0] = 8'h3C; bus.b_in[7:0] = 8'h15;
    bus.req[0] = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (bus.gnt == 2'b00 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_gnt", 32'(bus.gnt), 32'd1);
    bus.req[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_gnt0",     32'(bus.gnt),       32'd0);
    chk("abort_busy",     32'(bus.busy),      32'd0);
    chk("abort_done",     32'(bus.done),      32'd0);
    chk("abort_done_id",  32'(bus.done_id),   32'd0);
    chk("abort_result",   32'(bus.result),    32'd0);
    chk("abort_cout",     32'(bus.carry_out), 32'd0);
    chk("abort_ovf",      32'(bus.overflow),  32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    do_op(1, 1'b0, 8'h21, 8'h43, 8'h64, 1'b0, 1'b0, 0);

    // Contention: both requesters re-raise after each of their own dones.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    eg[0] = 2'b01; eg[1] = 2'b10; eg[2] = 2'b01; eg[3] = 2'b10;
    ca[0][0] = 8'h12; cb[0][0] = 8'h34; cop[0][0] = 1'b0; cr[0][0] = 8'h46; cc[0][0] = 1'b0;
    ca[1][0] = 8'h50; cb[1][0] = 8'h30; cop[1][0] = 1'b1; cr[1][0] = 8'h20; cc[1][0] = 1'b1;
    ca[0][1] = 8'hAA; cb[0][1] = 8'h55; cop[0][1] = 1'b0; cr[0][1] = 8'hFF; cc[0][1] = 1'b0;
    ca[1][1] = 8'h05; cb[1][1] = 8'h0A; cop[1][1] = 1'b1; cr[1][1] = 8'hFB; cc[1][1] = 1'b0;
    gcount[0] = 0; gcount[1] = 0;
    for (int i = 0; i < 2; i++) begin
      bus.a_in[i*8 +: 8] = ca[i][0];
      bus.b_in[i*8 +: 8] = cb[i][0];
      bus.ctrl_in[i]     = cop[i][0];
    end
    bus.req = 2'b11;
    ng = 0; dones = 0; cyc = 0;
    while (!(ng == 4 && dones == 4) && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt != 2'b00) begin
        if (ng < 4) chk("rr_gnt", 32'(bus.gnt), 32'(eg[ng]));
        gid = bus.gnt[1] ? 1 : 0;
        if (gcount[gid] < 2)
          sb.push_back('{gid, cr[gid][gcount[gid]], cc[gid][gcount[gid]], 1'b0});
        gcount[gid]++;
        bus.req[gid] = 1'b0;
        ng++;
      end
      if (bus.done === 1'b1) begin
        dones++;
        did = int'(bus.done_id);
        if (gcount[did] < 2) begin
          bus.a_in[did*8 +: 8] = ca[did][1];
          bus.b_in[did*8 +: 8] = cb[did][1];
          bus.ctrl_in[did]     = cop[did][1];
          bus.req[did]         = 1'b1;
        end
      end
    end
    chk("rr_complete", 32'(ng == 4 && dones == 4), 32'd1);
    bus.req = '0;
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
